alu_arbiter: RTL and testbench

Shares one instance of the team's combinational 4-bit ALU between `NUM_REQ` requesters. A round-robin grant selects a requester and registers its operands and opcode. The block then drives the ALU from those registers, captures the 8-bit signed result and returns it to the granted requester over a valid/ready handshake. It sits between the requester ports (sequencers, test drivers) and the ALU's `a`/`b`/`sel`/`y` pins; the ALU itself is instantiated outside this block.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the arbiter FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_INC_A  = 4'h0;
  localparam logic [3:0] OP_DEC_A  = 4'h1;
  localparam logic [3:0] OP_PASS_A = 4'h2;
  localparam logic [3:0] OP_PASS_B = 4'h3;
  localparam logic [3:0] OP_NEG_A  = 4'h4;
  localparam logic [3:0] OP_INC_B  = 4'h5;
  localparam logic [3:0] OP_ADD    = 4'h6;
  localparam logic [3:0] OP_SUB    = 4'h7;
  localparam logic [3:0] OP_NOT_A  = 4'h8;
  localparam logic [3:0] OP_NOT_B  = 4'h9;
  localparam logic [3:0] OP_AND    = 4'hA;
  localparam logic [3:0] OP_OR     = 4'hB;
  localparam logic [3:0] OP_XOR    = 4'hC;
  localparam logic [3:0] OP_NAND   = 4'hD;
  localparam logic [3:0] OP_XNOR   = 4'hE;
  localparam logic [3:0] OP_NOR    = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  always_comb begin : pick
    int idx;
    gnt    = '0;
    gnt_id = '0;
    // Scan from the farthest offset down so the nearest valid one is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// Handshake: a transfer happens on a rising edge where valid & ready are both high.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  input  logic [4*NUM_REQ-1:0] req_sel,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [7:0]           resp_y,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_sel,
  input  logic [7:0]           alu_y,
  output logic [15:0]          op_count,
  output arb_state_t           state_dbg
);

  arb_state_t          state, state_nxt;
  logic [ID_W-1:0]     ptr, gid;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     ptr_nxt;
  logic                accept, resp_done;
  logic [15:0]         op_cnt_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign ptr_nxt   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  assign op_count  = op_cnt_q;
  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    accept     = 1'b0;
    resp_done  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        if (|(req_valid & gnt)) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        resp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << gid;
        if (resp_ready[gid]) begin
          resp_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Handshake outputs are held low for as long as reset is asserted.
    if (rst) begin
      req_ready  = '0;
      resp_valid = '0;
      accept     = 1'b0;
      resp_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gid      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      resp_y   <= '0;
      op_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a   <= req_a[4*gnt_id +: 4];
        alu_b   <= req_b[4*gnt_id +: 4];
        alu_sel <= req_sel[4*gnt_id +: 4];
        gid     <= gnt_id;
        ptr     <= ptr_nxt;
      end
      if (state == EXEC) resp_y <= alu_y;
      if (resp_done) op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and arbitration model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 2;
  localparam int EW = 48;  // {id[7:0], y[7:0], accept_cycle[31:0]}

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [4*N-1:0]   req_a, req_b, req_sel;
  logic [7:0]       resp_y, alu_y;
  logic [3:0]       alu_a, alu_b, alu_sel;
  logic [15:0]      op_count;
  arb_state_t       state_dbg;

  logic [EW-1:0]    exp_q[$];
  int               grant_log[$];
  int               vectors = 0;
  int               miscompares = 0;
  int               cyc = 0;
  int               ptr_m = 0;
  bit               busy_m = 0;
  logic [15:0]      cnt_m = 16'd0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_y      (alu_y),
    .op_count   (op_count),
    .state_dbg  (state_dbg)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(logic [3:0] a, logic [3:0] b, logic [3:0] s);
    logic [3:0] r;
    case (s)
      OP_INC_A:  r = a + 4'd1;
      OP_DEC_A:  r = a - 4'd1;
      OP_PASS_A: r = a;
      OP_PASS_B: r = b;
      OP_NEG_A:  r = 4'd0 - a;
      OP_INC_B:  r = b + 4'd1;
      OP_ADD:    r = a + b;
      OP_SUB:    r = a - b;
      OP_NOT_A:  r = ~a;
      OP_NOT_B:  r = ~b;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_XNOR:   r = ~(a ^ b);
      default:   r = ~(a | b);
    endcase
    return {{4{r[3]}}, r};
  endfunction

  assign alu_y = alu_f(alu_a, alu_b, alu_sel);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Request-side model: predicts req_ready and pushes expected responses.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    bit found;
    int idx;
    if (rst) begin
      chk("rst_handshake_low", 32'({req_ready, resp_valid}), 32'd0);
      ptr_m  <= 0;
      busy_m <= 1'b0;
      exp_q.delete();
    end else begin
      exp_rdy = '0;
      found   = 1'b0;
      if (!busy_m) begin
        for (int k = 0; k < N; k++) begin
          idx = (ptr_m + k) % N;
          if (!found && req_valid[idx]) begin
            exp_rdy[idx] = 1'b1;
            found = 1'b1;
          end
        end
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && exp_rdy[i]) begin
          exp_q.push_back({8'(i), alu_f(req_a[4*i +: 4], req_b[4*i +: 4], req_sel[4*i +: 4]), 32'(cyc)});
          grant_log.push_back(i);
          ptr_m  <= (i + 1) % N;
          busy_m <= 1'b1;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard when the granted requester takes its result.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int id;
    if (rst) begin
      cnt_m <= 16'd0;
    end else begin
      chk("op_count", 32'(op_count), 32'(cnt_m));
      if (exp_q.size() != 0 && cyc >= int'(exp_q[0][31:0]) + 2) begin
        e  = exp_q[0];
        id = int'(e[47:40]);
        chk("resp_valid", 32'(resp_valid), 32'(1 << id));
        chk("resp_y", 32'(resp_y), 32'(e[39:32]));
        if (resp_ready[id]) begin
          void'(exp_q.pop_front());
          cnt_m  <= cnt_m + 16'd1;
          busy_m <= 1'b0;
        end
      end else begin
        chk("resp_valid_idle", 32'(resp_valid), 32'd0);
      end
    end
  end

  // Driver tasks
  task automatic set_req(int i, logic v, logic [3:0] a, logic [3:0] b, logic [3:0] s);
    req_valid[i]       = v;
    req_a[4*i +: 4]    = a;
    req_b[4*i +: 4]    = b;
    req_sel[4*i +: 4]  = s;
  endtask

  task automatic wait_hs(int i);
    bit got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) got = 1'b1;
    end
    if (!got) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(int i, logic [3:0] a, logic [3:0] b, logic [3:0] s);
    @(posedge clk); #1;
    set_req(i, 1'b1, a, b, s);
    wait_hs(i);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 80 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int start;
    logic [N-1:0] hs;
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
    resp_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_alu_a", 32'(alu_a), 32'd0);
    chk("reset_alu_b", 32'(alu_b), 32'd0);
    chk("reset_alu_sel", 32'(alu_sel), 32'd0);
    chk("reset_resp_y", 32'(resp_y), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));

    // Complete one op so ptr moves, then reset in the middle of the next one.
    resp_ready = '1;
    issue(0, 4'd1, 4'd1, OP_ADD);
    wait_idle();
    set_req(0, 1'b1, 4'd9, 4'd9, OP_ADD);
    wait_hs(0);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midop_resp_valid", 32'(resp_valid), 32'd0);
    chk("midop_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    chk("midop_op_count", 32'(op_count), 32'd0);

    // Single add on requester 0.
    issue(0, 4'd3, 4'd2, OP_ADD);
    wait_idle();
    chk("add_op_count", 32'(op_count), 32'd1);

    // Signed and logic ops on requester 1.
    issue(1, 4'd2, 4'd5, OP_SUB);
    issue(1, 4'hC, 4'hA, OP_AND);
    issue(1, 4'd0, 4'd0, OP_NOT_A);
    wait_idle();

    // Contention: both valid continuously for six grants; ptr is back at 0 here.
    start = grant_log.size();
    set_req(0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    set_req(1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    for (int t = 0; t < 100 && grant_log.size() < start + 6; t++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (hs[i])
          set_req(i, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    req_valid = '0;
    wait_idle();
    for (int k = 0; k < 6; k++)
      chk("contention_grant", 32'(grant_log[start + k]), 32'(k % 2));

    // Backpressure on requester 0 while requester 1 waits.
    resp_ready = 2'b10;
    set_req(0, 1'b1, 4'd7, 4'd3, OP_XOR);
    set_req(1, 1'b1, 4'd1, 4'd2, OP_OR);
    wait_hs(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (7) begin
      @(negedge clk);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = '1;
    wait_hs(1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // op_count wrap from a preloaded 0xFFFF.
    #1;
    dut.op_cnt_q = 16'hFFFF;
    cnt_m = 16'hFFFF;
    issue(0, 4'd5, 4'd5, OP_NAND);
    wait_idle();
    chk("wrap_op_count", 32'(op_count), 32'd0);

    // Random traffic with random backpressure and requests that may vanish.
    repeat (400) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      resp_ready = N'($urandom_range(0, (1 << N) - 1));
    end
    #1;
    req_valid  = '0;
    resp_ready = '1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
